// File: rtl/compact_target_encoder.sv
// Packs a 256-bit target into Bitcoin compact "nBits" form {size, mantissa}.
// Optional out_exact port under macro COMPACT_EXACT_EN.
module compact_target_encoder #(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_target,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_bits
`ifdef COMPACT_EXACT_EN
    ,
    output logic         out_exact
`endif
);

    localparam int GW   = 8 * BYTES_PER_CYCLE;
    localparam int NG   = 32 / BYTES_PER_CYCLE;
    localparam int GI_W = (NG > 1) ? $clog2(NG) : 1;

    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16 && BYTES_PER_CYCLE != 32) begin : g_bad_bpc
        $error("compact_target_encoder: BYTES_PER_CYCLE must be 1,2,4,8,16 or 32");
    end

    typedef enum logic [1:0] {IDLE, SCAN, NORM, DONE} state_t;

    state_t            state;
    logic [GI_W-1:0]   g;
    logic [255:0]      tgt;

    logic [NG-1:0][GW-1:0] grp;
    logic [GW-1:0]     cur_grp;
    logic              last_grp;

    // Group 0 is the most significant slice of the target.
    for (genvar i = 0; i < NG; i++) begin : g_grp
        assign grp[i] = tgt[255 - i*GW -: GW];
    end

    if (NG == 1) begin : g_one
        assign cur_grp = grp[0];
    end else begin : g_many
        assign cur_grp = grp[g];
    end

    assign last_grp = (g == GI_W'(NG - 1));

    // Leading zero bytes inside the group that stopped the scan.
    logic [5:0] lz_in;
    always_comb begin
        lz_in = 6'(BYTES_PER_CYCLE);
        for (int b = 0; b < BYTES_PER_CYCLE; b++) begin
            if (cur_grp[8*b +: 8] != 8'h00)
                lz_in = 6'(BYTES_PER_CYCLE - 1 - b);
        end
    end

    logic [5:0]   z;
    logic [7:0]   size_pre;
    logic [7:0]   size_fin;
    logic [279:0] ext;
    logic [23:0]  mant_raw;
    logic [23:0]  mant;
    logic         renorm;

    assign z        = 6'(g) * 6'(BYTES_PER_CYCLE) + lz_in;
    assign size_pre = 8'd32 - {2'b00, z};
    // 24 zero bits below the LSB make byte indices below 0 read as 0x00.
    assign ext      = {tgt, 24'h000000};
    assign mant_raw = 24'(ext >> {size_pre, 3'b000});
    assign renorm   = mant_raw[23];
    assign mant     = renorm ? {8'h00, mant_raw[23:8]} : mant_raw;
    assign size_fin = size_pre + {7'd0, renorm};

`ifdef COMPACT_EXACT_EN
    logic [10:0] ret_lsb;
    logic        exact_c;
    // Everything in ext below the retained mantissa must be zero.
    assign ret_lsb = {size_pre, 3'b000} + (renorm ? 11'd8 : 11'd0);
    assign exact_c = ((ext << (11'd280 - ret_lsb)) == '0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_bits  <= '0;
`ifdef COMPACT_EXACT_EN
            out_exact <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        tgt      <= in_target;
                        g        <= '0;
                        in_ready <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (cur_grp != '0 || last_grp)
                        state <= NORM;
                    else
                        g <= g + 1'b1;
                end
                NORM: begin
                    out_bits  <= {size_fin, mant};
`ifdef COMPACT_EXACT_EN
                    out_exact <= exact_c;
`endif
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
